mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter ADDR_WIDTH SHALL default to 5 and set the memory address width (depth 2**ADDR_WIDTH).
REQ-003 Parameter DATA_WIDTH SHALL default to 8 and set the memory word width.
REQ-004 Parameter WAIT_STATES SHALL default to 1 and set the number of wait cycles per access; legal range is 0..7.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 addr  input  ADDR_WIDTH  word address from the controller.
REQ-008 mem_rd  input  1  read strobe, level-held by the controller across several cycles.
REQ-009 mem_wr  input  1  write strobe, level-held by the controller.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 ready  output  1  single-cycle access-complete pulse.
REQ-013 busy  output  1  access in progress.
REQ-014 err  output  1  sticky flag for simultaneous mem_rd and mem_wr rising edges.
REQ-015 overrun  output  1  sticky flag for a strobe rising edge while not IDLE.

Function
REQ-016 Requests SHALL be edge-triggered: a request is a 0->1 transition of mem_rd or mem_wr, detected against registered previous values; a held-high level SHALL NOT retrigger.
REQ-017 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-018 In IDLE, a single rising edge SHALL capture addr (and data_in for writes) and the operation type; the FSM SHALL go to WAIT if WAIT_STATES>0, otherwise to RESP.
REQ-019 WAIT SHALL count exactly WAIT_STATES cycles and then go to RESP.
REQ-020 RESP SHALL last one cycle with ready=1 and then return to IDLE.
REQ-021 For an edge sampled in cycle N, ready SHALL be high in cycle N+1+WAIT_STATES only.
REQ-022 busy SHALL be high from cycle N+1 through the ready cycle inclusive, and low in IDLE.
REQ-023 Read: data_out SHALL take mem[captured addr] in the ready cycle and hold that value until the next read completes; writes SHALL NOT change data_out.
REQ-024 Write: mem[captured addr] SHALL be updated at the clock edge that enters RESP, so a read started after the write's ready returns the new data.
REQ-025 Changes to addr or data_in after the capture edge SHALL NOT affect the access in flight.
REQ-026 Simultaneous rising edges of mem_rd and mem_wr in IDLE SHALL perform no access, SHALL set err, and SHALL leave the FSM in IDLE with no ready pulse.
REQ-027 Any rising edge sampled in WAIT or RESP SHALL be dropped, SHALL set overrun, and SHALL NOT disturb the access in flight.
REQ-028 err and overrun SHALL clear only on reset.
REQ-029 Memory contents SHALL NOT be initialised by reset.

Reset
REQ-030 When rst=1 at a clock edge, the FSM SHALL go to IDLE, any access in flight SHALL be abandoned with no memory write, and data_out=0, ready=0, busy=0, err=0, overrun=0.
REQ-031 Reset SHALL clear the previous-strobe registers to 0, so a strobe already high in the first cycle after reset counts as a rising edge.

Verification (WAIT_STATES=1 unless stated)
REQ-032 Write mem_wr 0->1 at cycle 0 with addr=5'h03 and data_in=8'hA5, then a read of 5'h03 -> ready at cycle 2 for each access; read data_out=8'hA5.
REQ-033 mem_rd held high for 4 cycles -> exactly one ready pulse, and busy high for 2 cycles.
REQ-034 mem_rd and mem_wr rise together -> err=1, no ready, memory unchanged, busy stays 0.
REQ-035 A second mem_wr edge while busy -> overrun=1, the first write completes, and the second address is unmodified.
REQ-036 rst asserted during WAIT of a write to 5'h1F -> no ready, mem[5'h1F] retains its prior value, and all outputs are 0.
REQ-037 WAIT_STATES=0 and WAIT_STATES=7 -> ready at cycle N+1 and N+8 respectively.

Source files
------------

// File: rtl/mem_responder_if.sv
// Controller-to-responder bus for mem_responder.
// Strobes are level-held; the responder reacts to their rising edges.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready;
  logic                  busy;
  logic                  err;
  logic                  overrun;

  modport master (
    output addr, mem_rd, mem_wr, data_in,
    input  data_out, ready, busy, err, overrun
  );

  modport slave (
    input  addr, mem_rd, mem_wr, data_in,
    output data_out, ready, busy, err, overrun
  );
endinterface

// File: rtl/mem_responder.sv
// Edge-triggered single-port memory responder with
// programmable wait states and sticky error flags.
module mem_responder #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH = 8,
  parameter int WAIT_STATES = 1
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0] CNT_INIT =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_op_q, wr_op_d;
  logic                  rd_prev_q, rd_prev_d;
  logic                  wr_prev_q, wr_prev_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rd_rise, wr_rise;
  logic                  finish;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  acc_wr;
  logic                  mem_we;

  assign rd_rise = bus.mem_rd & ~rd_prev_q;
  assign wr_rise = bus.mem_wr & ~wr_prev_q;

  // With zero wait states the access completes straight
  // from IDLE, so it must use the live bus values.
  assign acc_addr = (state_q == S_IDLE) ? bus.addr : addr_q;
  assign acc_data = (state_q == S_IDLE) ? bus.data_in : data_q;
  assign acc_wr   = (state_q == S_IDLE) ? wr_rise : wr_op_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_op_d   = wr_op_q;
    rd_prev_d = bus.mem_rd;
    wr_prev_d = bus.mem_wr;
    dout_d    = dout_q;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    finish    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rd_rise && wr_rise) begin
          err_d = 1'b1;
        end else if (rd_rise || wr_rise) begin
          addr_d  = bus.addr;
          data_d  = bus.data_in;
          wr_op_d = wr_rise;
          busy_d  = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            finish = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (rd_rise || wr_rise) ovr_d = 1'b1;
        if (cnt_q == 3'd0) finish = 1'b1;
        else cnt_d = cnt_q - 3'd1;
      end
      S_RESP: begin
        if (rd_rise || wr_rise) ovr_d = 1'b1;
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    if (finish) begin
      state_d = S_RESP;
      ready_d = 1'b1;
      if (!acc_wr) dout_d = mem_q[acc_addr];
    end
  end

  assign mem_we = finish & acc_wr & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[acc_addr] <= acc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_op_q   <= 1'b0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      dout_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_op_q   <= wr_op_d;
      rd_prev_q <= rd_prev_d;
      wr_prev_q <= wr_prev_d;
      dout_q    <= dout_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.data_out = dout_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.overrun  = ovr_q;
endmodule
